// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg -- definitions shared by the instruction fetch stage.
//   if_state_e        : fetch FSM state encoding (BOOT, REQ, HOLD, DRAIN)
//   WORD_W            : instruction word / address width
//   RESET_PC_DEFAULT  : default fetch address after reset
package instr_fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } if_state_e;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_hold_buf.sv
// if_hold_buf -- one-entry buffer that parks a fetched word while decode
// is stalled.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   load                  : capture instr_in/pc_in and mark the entry valid
//   unload                : entry consumed, mark it empty
//   clear                 : discard the entry (flush); wins over load/unload
//   instr_in, pc_in       : word and its address to capture
//   valid, instr, pc      : current entry contents
module if_hold_buf
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_in,
  output logic              valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule : if_hold_buf

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch stage with a single outstanding memory
// request, a one-entry hold buffer for decode stalls and flush handling.
// Optional feature: define IF_PERF_CNT_EN to add the 32-bit perf_cnt output
// (saturating count of instructions accepted by decode).
// Ports:
//   clk, resetn             : clock, asynchronous active-low reset
//   flush, flush_pc         : squash and retarget fetch to flush_pc
//   stall                   : decode cannot take a new instruction
//   imem_req, imem_addr     : registered memory request / word address
//   imem_rdata, imem_ready  : memory response; ready completes the request
//   if_valid, if_instr,
//   if_pc                   : instruction presented to decode
//   perf_cnt                : (IF_PERF_CNT_EN only) accepted-instruction count
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_ready,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_cnt,
`endif
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc
);

  if_state_e         state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;          // address of the current/next fetch
  logic              req_q, req_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] ifpc_q, ifpc_d;

  logic              buf_load, buf_unload, buf_clear;
  logic              buf_valid;
  logic [WORD_W-1:0] buf_instr, buf_pc;

  logic              transfer;
  logic              slot_free;

  assign transfer  = req_q && imem_ready;
  assign slot_free = !valid_q || !stall;

  if_hold_buf u_hold_buf (
    .clk      (clk),
    .resetn   (resetn),
    .load     (buf_load),
    .unload   (buf_unload),
    .clear    (buf_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_clear  = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      ST_REQ: begin
        if (flush) begin
          valid_d   = 1'b0;
          buf_clear = 1'b1;
          pc_d      = flush_pc;
          if (imem_ready) begin
            // Old request completes this cycle: drop its data, retarget now.
            req_d  = 1'b1;
            addr_d = flush_pc;
          end else begin
            // Request still in flight; it must finish before retargeting.
            state_d = ST_DRAIN;
          end
        end else if (transfer && slot_free) begin
          valid_d = 1'b1;
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          pc_d    = pc_q + 16'd1;
          req_d   = 1'b1;
          addr_d  = pc_q + 16'd1;
        end else if (transfer) begin
          // Decode is holding the current word: park the new one.
          buf_load = 1'b1;
          req_d    = 1'b0;
          state_d  = ST_HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          valid_d   = 1'b0;
          buf_clear = 1'b1;
          pc_d      = flush_pc;
          req_d     = 1'b1;
          addr_d    = flush_pc;
          state_d   = ST_REQ;
        end else if (!stall) begin
          // pc_q still names the parked word, so the next fetch is pc_q+1.
          valid_d    = buf_valid;
          instr_d    = buf_instr;
          ifpc_d     = buf_pc;
          buf_unload = 1'b1;
          pc_d       = pc_q + 16'd1;
          req_d      = 1'b1;
          addr_d     = pc_q + 16'd1;
          state_d    = ST_REQ;
        end
      end

      ST_DRAIN: begin
        valid_d = 1'b0;
        if (flush) begin
          pc_d = flush_pc;
        end else if (imem_ready) begin
          // Stale word is dropped; start fetching at the flush target.
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (valid_q && !stall && !flush && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed self-checking bench for instr_fetch.
// Memory model returns 16'h1000 + address; latency is the number of
// waiting cycles before imem_ready rises for a request.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [15:0] flush_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
`ifdef IF_PERF_CNT_EN
    .perf_cnt   (perf_cnt),
`endif
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  // Memory model
  assign imem_rdata = 16'h1000 + imem_addr;
  assign imem_ready = imem_req && (wcnt >= lat);

  always_ff @(posedge clk) begin
    if (!imem_req || imem_ready) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".instr"}, {16'd0, if_instr}, {16'd0, ins});
      chk({tag, ".pc"},    {16'd0, if_pc},    {16'd0, pc});
    end
    $display("step %s valid=%0b instr=%h pc=%h req=%0b addr=%h",
             tag, if_valid, if_instr, if_pc, imem_req, imem_addr);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, a});
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; flush_pc = '0; stall = 1'b0;
    step(); step();
    chk_req("rst", 1'b0, 16'h0);
    chk("rst.addr", {16'd0, imem_addr}, 32'h0);
    chk("rst.instr", {16'd0, if_instr}, 32'h0);
    chk("rst.ifpc", {16'd0, if_pc}, 32'h0);
    chk_out("rst", 1'b0, 16'h0, 16'h0);

    // Zero-wait streaming
    resetn = 1'b1;
    step(); chk_req("boot", 1'b1, 16'h0000); chk_out("boot", 1'b0, 0, 0);
    step(); chk_out("s0", 1'b1, 16'h1000, 16'h0000);
    step(); chk_out("s1", 1'b1, 16'h1001, 16'h0001);
    step(); chk_out("s2", 1'b1, 16'h1002, 16'h0002); chk_req("s2", 1'b1, 16'h0003);

    // 3-cycle memory latency
    lat = 3;
    step(); chk_out("w1", 1'b0, 0, 0); chk_req("w1", 1'b1, 16'h0003);
    step(); chk_out("w2", 1'b0, 0, 0); chk_req("w2", 1'b1, 16'h0003);
    step(); chk_out("w3", 1'b0, 0, 0); chk_req("w3", 1'b1, 16'h0003);
    step(); chk_out("w4", 1'b1, 16'h1003, 16'h0003); chk_req("w4", 1'b1, 16'h0004);
    step(); chk_out("w5", 1'b0, 0, 0);
    lat = 0;
    step(); chk_out("w6", 1'b1, 16'h1004, 16'h0004);

    // Stall for 4 cycles while the next word completes
    stall = 1'b1;
    step(); chk_req("h1", 1'b0, 0); chk_out("h1", 1'b1, 16'h1004, 16'h0004);
    step(); chk_req("h2", 1'b0, 0); chk_out("h2", 1'b1, 16'h1004, 16'h0004);
    step(); chk_req("h3", 1'b0, 0);
    step(); chk_req("h4", 1'b0, 0); chk_out("h4", 1'b1, 16'h1004, 16'h0004);
    stall = 1'b0;
    step(); chk_out("h5", 1'b1, 16'h1005, 16'h0005); chk_req("h5", 1'b1, 16'h0006);
    step(); chk_out("h6", 1'b1, 16'h1006, 16'h0006);

    // Flush while the request waits for ready
    lat = 3; flush = 1'b1; flush_pc = 16'h0040;
    step(); chk_out("d1", 1'b0, 0, 0); chk_req("d1", 1'b1, 16'h0007);
    flush = 1'b0;
    step(); chk_req("d2", 1'b1, 16'h0007); chk_out("d2", 1'b0, 0, 0);
    step(); chk_req("d3", 1'b1, 16'h0007); chk_out("d3", 1'b0, 0, 0);
    step(); chk_req("d4", 1'b1, 16'h0040); chk_out("d4", 1'b0, 0, 0);
    lat = 0;
    step(); chk_out("d5", 1'b1, 16'h1040, 16'h0040);

    // Flush coinciding with ready, then PC wrap
    flush = 1'b1; flush_pc = 16'hFFFF;
    step(); chk_out("f1", 1'b0, 0, 0); chk_req("f1", 1'b1, 16'hFFFF);
    flush = 1'b0;
    step(); chk_out("f2", 1'b1, 16'h0FFF, 16'hFFFF); chk_req("f2", 1'b1, 16'h0000);
    step(); chk_out("f3", 1'b1, 16'h1000, 16'h0000);

    // Flush together with stall: flush wins
    stall = 1'b1; flush = 1'b1; flush_pc = 16'h0080;
    step(); chk_out("fs1", 1'b0, 0, 0); chk_req("fs1", 1'b1, 16'h0080);
    flush = 1'b0;
    // Stall with nothing valid has no effect
    step(); chk_out("fs2", 1'b1, 16'h1080, 16'h0080);
    step(); chk_req("fs3", 1'b0, 0); chk_out("fs3", 1'b1, 16'h1080, 16'h0080);
    // Flush in HOLD
    flush = 1'b1; flush_pc = 16'h0100;
    step(); chk_out("fh1", 1'b0, 0, 0); chk_req("fh1", 1'b1, 16'h0100);
    flush = 1'b0; stall = 1'b0;
    step(); chk_out("fh2", 1'b1, 16'h1100, 16'h0100);

    // Reset pulsed while in DRAIN
    lat = 3; flush = 1'b1; flush_pc = 16'h0200;
    step(); chk_req("r1", 1'b1, 16'h0101); chk_out("r1", 1'b0, 0, 0);
    flush = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("ar.req",   {31'd0, imem_req}, 32'h0);
    chk("ar.addr",  {16'd0, imem_addr}, 32'h0);
    chk("ar.valid", {31'd0, if_valid}, 32'h0);
    chk("ar.instr", {16'd0, if_instr}, 32'h0);
    chk("ar.ifpc",  {16'd0, if_pc}, 32'h0);
    $display("step async_reset req=%0b addr=%h valid=%0b", imem_req, imem_addr, if_valid);
    lat = 0;
    step();
    resetn = 1'b1;
    step(); chk_req("rb", 1'b1, 16'h0000);
    step(); chk_out("rb2", 1'b1, 16'h1000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000: the instruction fetch address used after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  squashes fetched instructions and retargets the PC to flush_pc.
REQ-005 flush_pc  input  16  new fetch address, sampled when flush=1.
REQ-006 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-007 imem_req  output  1  instruction memory request, registered.
REQ-008 imem_addr  output  16  word address of the request, registered.
REQ-009 imem_rdata  input  16  instruction word, valid when imem_ready=1.
REQ-010 imem_ready  input  1  completes the outstanding request this cycle.
REQ-011 if_valid  output  1  if_instr/if_pc hold a live instruction for decode.
REQ-012 if_instr  output  16  fetched instruction, feeding the decode stage's Instr input.
REQ-013 if_pc  output  16  address of if_instr.

Function
REQ-014 The FSM SHALL have the states BOOT, REQ, HOLD and DRAIN; a transfer is a cycle with imem_req=1 and imem_ready=1; slot_free = !if_valid || !stall.
REQ-015 Once asserted, imem_req and imem_addr SHALL stay constant until a transfer completes.
REQ-016 BOOT SHALL last exactly one cycle, then move to REQ with imem_req=1 and imem_addr=pc.
REQ-017 In REQ, a transfer with slot_free=1 SHALL load if_instr=imem_rdata, if_pc=pc and if_valid=1, set pc=pc+1, and issue the next request at pc+1 in the following cycle, giving 1 instr/cycle with a zero-wait memory.
REQ-018 In REQ, a transfer with slot_free=0 SHALL store the data and PC in a one-entry hold buffer, drop imem_req, and go to HOLD.
REQ-019 In REQ or HOLD with stall=0 and no new instruction to load, if_valid SHALL drop to 0.
REQ-020 In HOLD, stall=0 SHALL move the buffer to the outputs, set pc=pc+1 and return to REQ with a new request.
REQ-021 flush SHALL take priority over stall and over a transfer; the response SHALL be: if_valid=0, buffer discarded, pc=flush_pc.
REQ-022 A flush in REQ without imem_ready SHALL go to DRAIN, which keeps the old request until ready, discards that data, then enters REQ at pc.
REQ-023 A flush in REQ coinciding with imem_ready, or a flush in HOLD, SHALL discard the data and issue a request at flush_pc the next cycle.
REQ-024 A flush in DRAIN SHALL update pc to the latest flush_pc and stay in DRAIN.
REQ-025 pc arithmetic SHALL be 16-bit modulo, so that 16'hFFFF+1 = 16'h0000.
REQ-026 stall with if_valid=0 SHALL have no effect.

Reset
REQ-027 resetn=0 SHALL force state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, hold buffer cleared, and perf_cnt=0 when present.
REQ-028 Reset asserted mid-request SHALL abandon the request; the memory SHALL treat imem_req=0 as a cancel.

Configuration
REQ-029 With IF_PERF_CNT_EN defined, the block SHALL add the output perf_cnt (32-bit), which counts the cycles in which an instruction leaves if_valid=1 with stall=0 and flush=0, saturating at 32'hFFFFFFFF.
REQ-030 Without IF_PERF_CNT_EN, the perf_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the 16-bit word width constant and the RESET_PC default.
REQ-032 The hold buffer SHALL be implemented as the sub-module if_hold_buf (valid, instr, pc; load/unload/clear).

Verification
REQ-033 Reset release, RESET_PC=0, zero-wait memory returning 16'h1000+addr: the bench SHALL see if_instr = 1000, 1001, 1002 on consecutive cycles with if_pc = 0, 1, 2.
REQ-034 Memory ready delayed 3 cycles: imem_addr SHALL stay stable for 3 cycles and if_valid SHALL pulse once per delivered word.
REQ-035 stall held 4 cycles while a transfer completes: the word SHALL go to HOLD with imem_req=0, and after stall drops the instructions SHALL appear in order with none lost or duplicated.
REQ-036 flush with flush_pc=16'h0040 while waiting for ready: DRAIN SHALL discard the pending word, the next imem_addr SHALL be 16'h0040, and if_valid=0 in the cycle after the flush.
REQ-037 pc=16'hFFFF: the next fetch address SHALL be 16'h0000; flush coinciding with stall: the flush SHALL win.
REQ-038 resetn pulsed low mid-DRAIN: all outputs SHALL return to their reset values asynchronously and fetch SHALL restart at RESET_PC.
